// File: rtl/rca4_nibble_sequencer.sv
// rca4_nibble_sequencer: drives an external 4-bit ripple-carry adder one
// nibble per clock, LSB nibble first, and assembles the WIDTH-bit sum.
// The carry ripples between nibbles through r_carry.
// Optional feature macro: RCA_SEQ_SIGNED_OVF_EN adds a registered signed
// overflow flag output (ovf) that is valid alongside out_valid.
module rca4_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
`ifdef RCA_SEQ_SIGNED_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_last;
  logic               w_accept;

  assign w_last   = (r_idx == IDX_W'(NIB - 1));
  assign w_accept = (r_state == IDLE) && in_valid;

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake/adder-facing outputs; adder inputs idle at zero
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        add_a   = r_a[4*r_idx +: 4];
        add_b   = r_b[4*r_idx +: 4];
        add_cin = r_carry;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum/carry capture and nibble index stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_carry <= op_cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[4*r_idx +: 4] <= add_s;
      r_carry             <= add_cout;
      if (w_last) begin
        r_cout <= add_cout;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef RCA_SEQ_SIGNED_OVF_EN
  logic r_ovf;

  // Signed overflow captured on the final nibble, using the fresh MSB from the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_s[3] != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
